// File: rtl/panda_pkg.sv
// Shared register-file geometry and writeback request payload for the panda core.
package panda_pkg;

  localparam int unsigned RegDepth = 32;
  localparam int unsigned RegAddrW = $clog2(RegDepth);
  localparam int unsigned RegWidth = 32;

  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] addr;
    logic [RegWidth-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/panda_rr_arbiter.sv
// Generic round-robin arbiter: the search starts one past the last granted index.
module panda_rr_arbiter #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    idx   = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      if (!found && req_i[IdxW'((32'(last_q) + i) % NumReq)]) begin
        found = 1'b1;
        idx   = IdxW'((32'(last_q) + i) % NumReq);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[idx] = 1'b1;
  end

  assign gnt_idx_o   = idx;
  assign gnt_valid_o = found;

  // Reset pointer to the last index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= IdxW'(NumReq - 1);
    end else if (found) begin
      last_q <= idx;
    end
  end

endmodule

// File: rtl/panda_rf_wb_arbiter.sv
// Shares the register-file write port among writeback sources and tracks
// pending long-latency writes so decode can stall on RAW hazards.
module panda_rf_wb_arbiter
  import panda_pkg::*;
#(
  parameter  int unsigned NumReq = 2,
  parameter  int unsigned Width  = RegWidth,
  parameter  int unsigned Depth  = RegDepth,
  localparam int unsigned AddrW  = $clog2(Depth)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            wb_valid_i,
  output logic [NumReq-1:0]            wb_ready_o,
  input  logic [NumReq-1:0][AddrW-1:0] wb_addr_i,
  input  logic [NumReq-1:0][Width-1:0] wb_data_i,
  output logic [AddrW-1:0]             rf_addr_o,
  output logic [Width-1:0]             rf_data_o,
  output logic                         rf_we_o,
  input  logic                         issue_valid_i,
  input  logic [AddrW-1:0]             issue_addr_i,
  input  logic [AddrW-1:0]             rs1_addr_i,
  input  logic [AddrW-1:0]             rs2_addr_i,
  input  logic [AddrW-1:0]             rd_addr_i,
  output logic                         rs1_busy_o,
  output logic                         rs2_busy_o,
  output logic                         rd_busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_valid;
  logic [Depth-1:0] busy_q;
  logic [Depth-1:0] busy_d;

  panda_rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (wb_valid_i),
    .gnt_o       (wb_ready_o),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Output stage; address and data hold when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o   <= 1'b0;
      rf_addr_o <= '0;
      rf_data_o <= '0;
    end else begin
      rf_we_o <= gnt_valid;
      if (gnt_valid) begin
        rf_addr_o <= wb_addr_i[gnt_idx];
        rf_data_o <= wb_data_i[gnt_idx];
      end
    end
  end

  // Clear on retire, then set on issue so a same-cycle reissue stays pending.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_o) busy_d[rf_addr_o] = 1'b0;
    if (issue_valid_i) busy_d[issue_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];
  assign rd_busy_o  = busy_q[rd_addr_i];

endmodule

// File: tb/tb_panda_rf_wb_arbiter.sv
// Directed and randomised checks of the writeback arbiter and its pending-write scoreboard.
module tb_panda_rf_wb_arbiter;

  localparam int unsigned NumReq = 2;
  localparam int unsigned Width  = 32;
  localparam int unsigned Depth  = 32;
  localparam int unsigned AddrW  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NumReq-1:0]            wb_valid;
  logic [NumReq-1:0]            wb_ready;
  logic [NumReq-1:0][AddrW-1:0] wb_addr;
  logic [NumReq-1:0][Width-1:0] wb_data;
  logic [AddrW-1:0]             rf_addr;
  logic [Width-1:0]             rf_data;
  logic                         rf_we;
  logic                         issue_valid;
  logic [AddrW-1:0]             issue_addr;
  logic [AddrW-1:0]             rs1_addr, rs2_addr, rd_addr;
  logic                         rs1_busy, rs2_busy, rd_busy;

  panda_rf_wb_arbiter #(
    .NumReq (NumReq),
    .Width  (Width),
    .Depth  (Depth)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wb_valid_i    (wb_valid),
    .wb_ready_o    (wb_ready),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .rf_addr_o     (rf_addr),
    .rf_data_o     (rf_data),
    .rf_we_o       (rf_we),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rd_addr_i     (rd_addr),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .rd_busy_o     (rd_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NumReq-1:0] v, input int last);
    int c;
    for (int i = 1; i <= int'(NumReq); i++) begin
      c = (last + i) % int'(NumReq);
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Reference model of the output stage and scoreboard
  int               m_last;
  int               m_g;
  logic             m_we;
  logic [AddrW-1:0] m_addr;
  logic [Width-1:0] m_data;
  logic [Depth-1:0] m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = int'(NumReq) - 1;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_busy = '0;
    end else begin
      m_g = pick(wb_valid, m_last);
      if (m_we && m_addr != 0) m_busy[m_addr] = 1'b0;
      if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      if (m_g >= 0) begin
        m_we   = 1'b1;
        m_addr = wb_addr[1'(m_g)];
        m_data = wb_data[1'(m_g)];
        m_last = m_g;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // Protocol monitor: held requests, starvation bound, WAW issue
  logic [NumReq-1:0]            held;
  logic [NumReq-1:0][AddrW-1:0] held_addr;
  logic [NumReq-1:0][Width-1:0] held_data;
  int                           wait_cnt [NumReq];
  bit                           rnd_on = 1'b0;
  int                           n_wr = 0;
  int                           n_req = 0;
  logic [1:0]                   exp_rdy;
  int                           p;

  always @(posedge clk or negedge rst_n) begin
    for (int r = 0; r < int'(NumReq); r++) begin
      if (!rst_n) begin
        held[r]     = 1'b0;
        wait_cnt[r] = 0;
      end else begin
        held[r]      = wb_valid[r] & ~wb_ready[r];
        held_addr[r] = wb_addr[r];
        held_data[r] = wb_data[r];
        wait_cnt[r]  = held[r] ? wait_cnt[r] + 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      p = pick(wb_valid, m_last);
      exp_rdy = (p < 0) ? 2'b00 : 2'(1 << p);
      check("mdl_ready", 64'(wb_ready), 64'(exp_rdy));
      check("mdl_we", 64'(rf_we), 64'(m_we));
      check("mdl_addr", 64'(rf_addr), 64'(m_addr));
      check("mdl_data", 64'(rf_data), 64'(m_data));
      check("mdl_rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr]));
      check("mdl_rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr]));
      check("mdl_rd_busy", 64'(rd_busy), 64'(m_busy[rd_addr]));
      for (int r = 0; r < int'(NumReq); r++) begin
        if (held[r]) begin
          check("hold_valid", 64'(wb_valid[r]), 64'h1);
          check("hold_addr", 64'(wb_addr[r]), 64'(held_addr[r]));
          check("hold_data", 64'(wb_data[r]), 64'(held_data[r]));
        end
        if (wb_valid[r]) check("starve", 64'(wait_cnt[r] <= int'(NumReq) - 1), 64'h1);
      end
      if (issue_valid && issue_addr != 0) check("waw_issue", 64'(m_busy[issue_addr]), 64'h0);
      if (rnd_on && rf_we) n_wr++;
    end
  end

  logic [1:0]  t2_rdy  [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
  logic [4:0]  t2_addr [5] = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1};
  logic [31:0] t2_data [5] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2};
  logic [1:0]  gr;
  logic [4:0]  a;

  initial begin
    wb_valid = '0; wb_addr = '0; wb_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
    rs1_addr = 5'd7; rs2_addr = 5'd8; rd_addr = 5'd1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", 64'(rf_we), 64'h0);
    check("rst_addr", 64'(rf_addr), 64'h0);
    check("rst_data", 64'(rf_data), 64'h0);
    check("rst_busy", 64'({rs1_busy, rs2_busy, rd_busy}), 64'h0);
    rst_n = 1'b1;

    // Single requester
    tick(); wb_valid = 2'b10; wb_addr[1] = 5'd5; wb_data[1] = 32'hDEADBEEF;
    @(negedge clk); check("t1_ready", 64'(wb_ready), 64'h2);
    tick(); wb_valid = 2'b00;
    @(negedge clk);
    check("t1_we", 64'(rf_we), 64'h1);
    check("t1_addr", 64'(rf_addr), 64'h5);
    check("t1_data", 64'(rf_data), 64'hDEADBEEF);
    tick();
    @(negedge clk);
    check("t1_we_off", 64'(rf_we), 64'h0);
    check("t1_addr_hold", 64'(rf_addr), 64'h5);

    // Round-robin between two held requesters
    tick(); wb_valid = 2'b11; wb_addr[0] = 5'd1; wb_addr[1] = 5'd2;
    wb_data[0] = 32'hA0; wb_data[1] = 32'hB0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_ready", 64'(wb_ready), 64'(t2_rdy[k]));
      if (k > 0) begin
        check("t2_we", 64'(rf_we), 64'h1);
        check("t2_addr", 64'(rf_addr), 64'(t2_addr[k-1]));
        check("t2_data", 64'(rf_data), 64'(t2_data[k-1]));
      end
      tick();
      if (k % 2 == 0) wb_data[0] = wb_data[0] + 32'h1;
      else            wb_data[1] = wb_data[1] + 32'h1;
      if (k == 3) wb_valid[1] = 1'b0;
      if (k == 4) wb_valid = 2'b00;
    end
    @(negedge clk);
    check("t2_last_addr", 64'(rf_addr), 64'h1);
    check("t2_last_data", 64'(rf_data), 64'hA2);
    tick();
    @(negedge clk); check("t2_we_off", 64'(rf_we), 64'h0);

    // Scoreboard set by issue, cleared by writeback
    rs1_addr = 5'd7; rs2_addr = 5'd8; rd_addr = 5'd7;
    tick(); issue_valid = 1'b1; issue_addr = 5'd7;
    @(negedge clk); check("t3_c0_busy", 64'(rs1_busy), 64'h0);
    tick(); issue_valid = 1'b0;
    @(negedge clk);
    check("t3_c1_busy", 64'(rs1_busy), 64'h1);
    check("t3_c1_rd", 64'(rd_busy), 64'h1);
    check("t3_c1_rs2", 64'(rs2_busy), 64'h0);
    tick();
    @(negedge clk); check("t3_c2_busy", 64'(rs1_busy), 64'h1);
    tick(); wb_valid = 2'b10; wb_addr[1] = 5'd7; wb_data[1] = 32'h77;
    @(negedge clk);
    check("t3_c3_ready", 64'(wb_ready), 64'h2);
    check("t3_c3_busy", 64'(rs1_busy), 64'h1);
    tick(); wb_valid = 2'b00;
    @(negedge clk);
    check("t3_c4_we", 64'(rf_we), 64'h1);
    check("t3_c4_addr", 64'(rf_addr), 64'h7);
    check("t3_c4_busy", 64'(rs1_busy), 64'h1);
    tick();
    @(negedge clk);
    check("t3_c5_busy", 64'(rs1_busy), 64'h0);
    check("t3_c5_we", 64'(rf_we), 64'h0);

    // Simultaneous set and clear; issue to x0
    rs1_addr = 5'd9; rs2_addr = 5'd3; rd_addr = 5'd0;
    tick(); wb_valid = 2'b10; wb_addr[1] = 5'd9; wb_data[1] = 32'h99;
    @(negedge clk); check("t4_ready", 64'(wb_ready), 64'h2);
    tick(); wb_valid = 2'b00; issue_valid = 1'b1; issue_addr = 5'd9;
    @(negedge clk);
    check("t4_we", 64'(rf_we), 64'h1);
    check("t4_addr", 64'(rf_addr), 64'h9);
    check("t4_pre_busy", 64'(rs1_busy), 64'h0);
    tick(); issue_addr = 5'd0;
    @(negedge clk); check("t4_set_wins", 64'(rs1_busy), 64'h1);
    tick(); issue_valid = 1'b0;
    @(negedge clk);
    check("t4_x0_busy", 64'(rd_busy), 64'h0);
    check("t4_9_still", 64'(rs1_busy), 64'h1);
    check("t4_3_idle", 64'(rs2_busy), 64'h0);
    tick(); wb_valid = 2'b10; wb_addr[1] = 5'd9; wb_data[1] = 32'h9A;
    @(negedge clk);
    tick(); wb_valid = 2'b00;
    @(negedge clk); check("t4_clr_pending", 64'(rs1_busy), 64'h1);
    tick();
    @(negedge clk); check("t4_cleared", 64'(rs1_busy), 64'h0);

    // Reset in the middle of traffic
    rs1_addr = 5'd3; rs2_addr = 5'd4; rd_addr = 5'd0;
    tick(); issue_valid = 1'b1; issue_addr = 5'd3;
    tick(); issue_addr = 5'd4;
    tick(); issue_valid = 1'b0; wb_valid = 2'b01; wb_addr[0] = 5'd10; wb_data[0] = 32'h1010;
    @(negedge clk);
    check("t5_busy3", 64'(rs1_busy), 64'h1);
    check("t5_busy4", 64'(rs2_busy), 64'h1);
    check("t5_ready0", 64'(wb_ready), 64'h1);
    tick(); wb_valid = 2'b11;
    wb_addr[0] = 5'd11; wb_data[0] = 32'h1111;
    wb_addr[1] = 5'd12; wb_data[1] = 32'h1212;
    @(negedge clk);
    check("t5_pre_ready", 64'(wb_ready), 64'h2);
    check("t5_pre_we", 64'(rf_we), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_we", 64'(rf_we), 64'h0);
    check("t5_rst_addr", 64'(rf_addr), 64'h0);
    check("t5_rst_data", 64'(rf_data), 64'h0);
    check("t5_rst_busy", 64'({rs1_busy, rs2_busy}), 64'h0);
    check("t5_rst_ready", 64'(wb_ready), 64'h1);
    #1 rst_n = 1'b1;
    tick(); wb_valid = 2'b10;
    @(negedge clk);
    check("t5_post_addr", 64'(rf_addr), 64'd11);
    check("t5_post_data", 64'(rf_data), 64'h1111);
    check("t5_post_ready", 64'(wb_ready), 64'h2);
    tick(); wb_valid = 2'b00;
    @(negedge clk);
    check("t5_post2_addr", 64'(rf_addr), 64'd12);
    check("t5_post2_data", 64'(rf_data), 64'h1212);
    tick();

    // Random traffic against the model
    rnd_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      gr = wb_valid & wb_ready;
      tick();
      for (int r = 0; r < int'(NumReq); r++) begin
        if (gr[r] || !wb_valid[r]) begin
          if ($urandom_range(0, 2) != 0) begin
            wb_valid[r] = 1'b1;
            wb_addr[r]  = 5'($urandom_range(0, 31));
            wb_data[r]  = $urandom;
            n_req++;
          end else begin
            wb_valid[r] = 1'b0;
          end
        end
      end
      issue_valid = 1'b0;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0 && !m_busy[a]) begin
        issue_valid = 1'b1;
        issue_addr  = a;
      end
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      rd_addr  = 5'($urandom_range(0, 31));
    end
    issue_valid = 1'b0;
    for (int d = 0; d < 6; d++) begin
      @(negedge clk);
      gr = wb_valid & wb_ready;
      tick();
      wb_valid = wb_valid & ~gr;
    end
    rnd_on = 1'b0;
    check("rnd_drained", 64'(wb_valid), 64'h0);
    check("rnd_write_count", 64'(n_wr), 64'(n_req));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/panda_rf_wb_arbiter.md
# panda_rf_wb_arbiter

Shares the single register-file write port (rd) between several writeback sources: the in-order execute stage and long-latency units such as load/store and mul/div. Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards against in-flight long-latency results. Sits between the writeback sources and `panda_register_file`, driving its `rd_addr_i`/`rd_data_i`/`rd_we_i` from a registered output stage.

## Interface
- `NumReq`, default 2: number of writeback requesters; index 0 is execute.
- `Width`, default 32: data width.
- `Depth`, default 32: register count; `AddrW = $clog2(Depth)`.

Ports:
- `clk_i` in 1: clock; one clock domain.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `wb_valid_i` in [NumReq]: requester i has a result.
- `wb_ready_o` out [NumReq]: grant; a transfer occurs when valid and ready are both high.
- `wb_addr_i` in [NumReq][AddrW]: destination register.
- `wb_data_i` in [NumReq][Width]: result data.
- `rf_addr_o` out AddrW: to register file `rd_addr_i`.
- `rf_data_o` out Width: to register file `rd_data_i`.
- `rf_we_o` out 1: to register file `rd_we_i`.
- `issue_valid_i` in 1: decode issues a long-latency op.
- `issue_addr_i` in AddrW: its destination register.
- `rs1_addr_i`, `rs2_addr_i`, `rd_addr_i` in AddrW: hazard query addresses.
- `rs1_busy_o`, `rs2_busy_o`, `rd_busy_o` out 1: queried register has a pending write.

## Operation
- Arbitration is round-robin over valid requesters. A priority pointer `last_q` holds the most recently granted index; the search starts at `last_q+1` and wraps modulo NumReq.
  - On reset `last_q = NumReq-1`, so requester 0 has priority first.
  - `last_q` updates only on a grant.
- At most one `wb_ready_o` is high per cycle. Ready is combinational from the valid inputs and `last_q`. No requester waits more than NumReq-1 cycles once its valid is high.
- The register file always accepts, so the output stage never back-pressures. On a grant, the next cycle shows `rf_we_o=1` with the granted address and data. With no grant, the next cycle shows `rf_we_o=0`, and `rf_addr_o`/`rf_data_o` hold their previous values.
- Requesters must hold valid, address and data stable until granted. Dropping valid without a grant is illegal; the bench asserts it.
- Scoreboard `busy_q[Depth-1:1]`, with bit 0 hardwired to 0:
  - `issue_valid_i` with a nonzero address sets the bit at the clock edge.
  - `rf_we_o=1` clears `busy_q[rf_addr_o]` at the end of that cycle, the same edge on which the register file stores the data.
  - Set and clear to the same address in one cycle: set wins, because the new issue is newer.
  - Issuing to a register that is already busy is illegal (WAW); decode must stall on `rd_busy_o`. The bench asserts it.
- `*_busy_o = busy_q[addr]` is combinational, with no bypass. A register reads not busy in the cycle after its `rf_we_o` cycle, when the register file holds the new value.
- Writes to x0 are granted and forwarded unchanged; the register file discards them. They never touch the scoreboard.
- The execute requester (index 0) never issues through the scoreboard. Its hazards are handled by pipeline forwarding elsewhere.

## Timing
- Reset values: `rf_we_o=0`, `rf_addr_o=0`, `rf_data_o=0`, all `busy_q=0`, so all `*_busy_o=0`.
- Reset mid-operation clears the scoreboard and the output stage immediately (asynchronous). In-flight results are lost; upstream resets too.
- Latency from grant to `rf_we_o`: 1 cycle.
- Latency from grant to busy cleared as seen at query: 2 cycles.
- Latency from issue to `*_busy_o` high: 1 cycle.
- Throughput: one write per cycle.

## Structure
- `panda_pkg` holds:
  - `RegAddrW` and `RegDepth` constants;
  - the `wb_req_t` struct {valid, addr, data}, so requester ports can be bundled if desired.
- Natural sub-module: `panda_rr_arbiter`, a generic NumReq round-robin arbiter with request, grant one-hot and pointer update. It is reusable for the memory port.
- The scoreboard and output register stay in this module.

## Test plan
- **Single requester:** req1 valid, addr 5, data 0xDEADBEEF at cycle 0. Required: `wb_ready_o[1]=1` at cycle 0; at cycle 1 `rf_we_o=1`, `rf_addr_o=5`, `rf_data_o=0xDEADBEEF`; at cycle 2 `rf_we_o=0`.
- **Round-robin:** both requesters valid for 4 cycles, addresses 1 and 2. Required: grants in order 0,1,0,1; each requester's data is held until its grant; exactly one `rf_we_o` per cycle.
- **Scoreboard:** issue addr 7, then req1 writes addr 7 three cycles later. Required: `rs1_busy_o` (rs1=7) is high from cycle 1 until the cycle after `rf_we_o`, then low.
- **Simultaneous set and clear:** issue addr 9 in the same cycle as `rf_we_o` for addr 9. Required: `busy[9]` stays 1. An issue to addr 0 leaves all busy bits 0.
- **Reset mid-operation:** busy bits 3 and 4 set and a grant pending; pulse `rst_ni` low asynchronously. Required: all busy 0, `rf_we_o=0`, and requester 0 granted first after reset.
- **Random:** random valids and issues with a reference model. Required: no lost or duplicated writes, and no starvation beyond NumReq-1 cycles.
